// File: rtl/vga_scan_ctrl.sv
// ---------------------------------------------------------------------------
// vga_scan_ctrl
//
// Raster scan controller for the ADV7123 video DAC. Generates the x_cnt/y_cnt
// coordinates that the sprite layers decode combinationally, captures their
// colour reply one pixel later, and drives the DAC pins with blanking and
// syncs registered on the same pixel edge as the colour. All pins therefore
// lag the counters by exactly one pixel and stay mutually aligned.
//
// Optional feature macro: VGA_SCAN_BARS_EN
//   Defined   : bar_en=1 replaces sprite colour with 8 vertical colour bars
//               (black, blue, green, cyan, red, magenta, yellow, white).
//   Undefined : bar_en is ignored and no bar logic exists.
//
// Flow control: pix_en is the only qualifier. Every register advances on a
// clk edge where pix_en=1 and holds otherwise; there is no backpressure, so
// a pixel slot lasts exactly as many clks as pix_en stays low plus one.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   pix_en       pixel-rate enable (tie high for a native pixel clock)
//   r_data/g_data/b_data  sprite colour for the current x_cnt/y_cnt
//   bar_en       test-bar select (only with VGA_SCAN_BARS_EN)
//   x_cnt/y_cnt  raster position; visible when below H_ACTIVE/V_ACTIVE
//   frame_start  high for the whole pixel slot at (0,0)
//   vga_r/g/b    DAC colour, zero outside the visible area
//   vga_hs/vs    active-low syncs
//   vga_blank_n  low outside the visible area
//   vga_sync_n   constant 0 (no sync-on-green)
// ---------------------------------------------------------------------------
module vga_scan_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    input  logic [7:0] r_data,
    input  logic [7:0] g_data,
    input  logic [7:0] b_data,
    input  logic       bar_en,
    output logic [9:0] x_cnt,
    output logic [9:0] y_cnt,
    output logic       frame_start,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_sync_n
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_PAST    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_PAST    = 10'(V_ACTIVE + V_FP + V_SYNC);

    // ------------------------------------------------------------------
    // Next-coordinate logic. ">=" on the wrap compare keeps the counters
    // self-recovering even though out-of-range values cannot arise.
    // ------------------------------------------------------------------
    logic       x_wrap;
    logic       y_wrap;
    logic [9:0] x_next;
    logic [9:0] y_next;

    always_comb begin
        x_wrap = (x_cnt >= H_LAST);
        y_wrap = (y_cnt >= V_LAST);
        x_next = x_wrap ? 10'd0 : x_cnt + 10'd1;
        y_next = y_cnt;
        if (x_wrap) begin
            y_next = y_wrap ? 10'd0 : y_cnt + 10'd1;
        end
    end

    // ------------------------------------------------------------------
    // Timing decode from the current (pre-increment) counters. These are
    // registered together with the colour, so the pins describe the pixel
    // the counters pointed at on the previous slot.
    // ------------------------------------------------------------------
    logic active;
    logic hs_n;
    logic vs_n;

    always_comb begin
        active = (x_cnt < H_VIS) && (y_cnt < V_VIS);
        hs_n   = !((x_cnt >= HS_FIRST) && (x_cnt < HS_PAST));
        vs_n   = !((y_cnt >= VS_FIRST) && (y_cnt < VS_PAST));
    end

    // ------------------------------------------------------------------
    // Colour source selection
    // ------------------------------------------------------------------
    logic [23:0] src_rgb;

`ifdef VGA_SCAN_BARS_EN
    localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

    // Index beyond 7 only occurs outside the visible area, where the pins
    // are forced to zero anyway, so truncation to 3 bits is harmless.
    logic [2:0] bar_idx;

    always_comb begin
        bar_idx = 3'(x_cnt / BAR_W);
        src_rgb = {r_data, g_data, b_data};
        if (bar_en) begin
            src_rgb = {{8{bar_idx[2]}}, {8{bar_idx[1]}}, {8{bar_idx[0]}}};
        end
    end
`else
    logic unused_bar_en;
    assign unused_bar_en = bar_en;

    always_comb begin
        src_rgb = {r_data, g_data, b_data};
    end
`endif

    // ------------------------------------------------------------------
    // Counters, frame marker and DAC pin registers. frame_start is computed
    // from the next coordinates so it is high for the entire (0,0) slot,
    // including any clks where pix_en holds the slot.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt       <= 10'd0;
            y_cnt       <= 10'd0;
            frame_start <= 1'b1;
            vga_r       <= 8'd0;
            vga_g       <= 8'd0;
            vga_b       <= 8'd0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
        end else if (pix_en) begin
            x_cnt       <= x_next;
            y_cnt       <= y_next;
            frame_start <= (x_next == 10'd0) && (y_next == 10'd0);
            if (active) begin
                {vga_r, vga_g, vga_b} <= src_rgb;
            end else begin
                {vga_r, vga_g, vga_b} <= 24'd0;
            end
            vga_blank_n <= active;
            vga_hs      <= hs_n;
            vga_vs      <= vs_n;
        end
    end

    assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for vga_scan_ctrl.
//
// Two instances share the clock: "d" uses the default 640x480 timing for
// line-level behaviour (pipeline, sync position, half rate, test bars);
// "s" uses a tiny 25x11 raster so whole frames (wrap, vsync, frame period,
// mid-frame reset) fit in a short run. Each instance has a bench-side
// coordinate model producing the expected pins for every pixel edge.
// ---------------------------------------------------------------------------
module tb_vga_scan_ctrl;

    localparam int D_HA = 640, D_HF = 16, D_HS = 96, D_HB = 48;
    localparam int D_VA = 480, D_VF = 10, D_VS = 2,  D_VB = 33;
    localparam int S_HA = 16,  S_HF = 2,  S_HS = 4,  S_HB = 3;
    localparam int S_VA = 6,   S_VF = 1,  S_VS = 2,  S_VB = 2;

    localparam logic [47:0] RST_V = {10'd0, 10'd0, 1'b1, 24'd0, 1'b1, 1'b1, 1'b0};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic rst_d, rst_s, pe_d, pe_s;
    logic bar_en, data_mode;

    // ---------------- DUT signals ----------------
    logic [7:0] r_d, g_d, b_d, r_s, g_s, b_s;
    logic [9:0] x_d, y_d, x_s, y_s;
    logic       fs_d, fs_s, hs_d, hs_s, vs_d, vs_s, bl_d, bl_s, sn_d, sn_s;
    logic [7:0] vr_d, vg_d, vb_d, vr_s, vg_s, vb_s;

    vga_scan_ctrl dut_d (
        .clk(clk), .rst_n(rst_d), .pix_en(pe_d),
        .r_data(r_d), .g_data(g_d), .b_data(b_d), .bar_en(bar_en),
        .x_cnt(x_d), .y_cnt(y_d), .frame_start(fs_d),
        .vga_r(vr_d), .vga_g(vg_d), .vga_b(vb_d),
        .vga_hs(hs_d), .vga_vs(vs_d), .vga_blank_n(bl_d), .vga_sync_n(sn_d)
    );

    vga_scan_ctrl #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
    ) dut_s (
        .clk(clk), .rst_n(rst_s), .pix_en(pe_s),
        .r_data(r_s), .g_data(g_s), .b_data(b_s), .bar_en(bar_en),
        .x_cnt(x_s), .y_cnt(y_s), .frame_start(fs_s),
        .vga_r(vr_s), .vga_g(vg_s), .vga_b(vb_s),
        .vga_hs(hs_s), .vga_vs(vs_s), .vga_blank_n(bl_s), .vga_sync_n(sn_s)
    );

    // Sprite-layer stand-in: combinational colour from the coordinates.
    always_comb begin
        r_d = data_mode ? 8'h12 : x_d[7:0];
        g_d = data_mode ? 8'h12 : y_d[7:0];
        b_d = data_mode ? 8'h12 : (x_d[7:0] ^ 8'hA5);
        r_s = data_mode ? 8'h12 : x_s[7:0];
        g_s = data_mode ? 8'h12 : y_s[7:0];
        b_s = data_mode ? 8'h12 : (x_s[7:0] ^ 8'hA5);
    end

    wire [47:0] obs_d = {x_d, y_d, fs_d, vr_d, vg_d, vb_d, hs_d, vs_d, bl_d};
    wire [47:0] obs_s = {x_s, y_s, fs_s, vr_s, vg_s, vb_s, hs_s, vs_s, bl_s};

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    int mx [2];
    int my [2];
    logic [47:0] exp_v [2];

    function automatic logic [47:0] obs(input int inst);
        return (inst == 0) ? obs_d : obs_s;
    endfunction

    // Expected {r,g,b,hs,vs,blank_n} for the pixel at (x,y).
    function automatic logic [26:0] pins(input int x, input int y,
                                         input int ha, input int hf, input int hsw,
                                         input int va, input int vf, input int vsw,
                                         input logic dm);
        logic act, h_n, v_n;
        logic [7:0] xb, yb, r, g, b;
        xb  = 8'(x);
        yb  = 8'(y);
        act = (x < ha) && (y < va);
        h_n = !((x >= ha + hf) && (x < ha + hf + hsw));
        v_n = !((y >= va + vf) && (y < va + vf + vsw));
        r = dm ? 8'h12 : xb;
        g = dm ? 8'h12 : yb;
        b = dm ? 8'h12 : (xb ^ 8'hA5);
        if (!act) begin
            r = 8'd0; g = 8'd0; b = 8'd0;
        end
        return {r, g, b, h_n, v_n, act};
    endfunction

    // ---------------- driver tasks ----------------
    // One pix_en edge on an instance; the model advances in step.
    task automatic pix_edge(input int inst, input bit chk);
        logic [26:0] p;
        int ht, vt;
        if (inst == 0) begin
            p  = pins(mx[0], my[0], D_HA, D_HF, D_HS, D_VA, D_VF, D_VS, data_mode);
            ht = D_HA + D_HF + D_HS + D_HB;
            vt = D_VA + D_VF + D_VS + D_VB;
        end else begin
            p  = pins(mx[1], my[1], S_HA, S_HF, S_HS, S_VA, S_VF, S_VS, data_mode);
            ht = S_HA + S_HF + S_HS + S_HB;
            vt = S_VA + S_VF + S_VS + S_VB;
        end
        mx[inst] = mx[inst] + 1;
        if (mx[inst] == ht) begin
            mx[inst] = 0;
            my[inst] = my[inst] + 1;
            if (my[inst] == vt) my[inst] = 0;
        end
        exp_v[inst] = {10'(mx[inst]), 10'(my[inst]), (mx[inst] == 0 && my[inst] == 0), p};
        if (inst == 0) pe_d = 1'b1; else pe_s = 1'b1;
        @(posedge clk);
        #1;
        pe_d = 1'b0;
        pe_s = 1'b0;
        if (chk) begin
            checks++;
            if (obs(inst) !== exp_v[inst]) begin
                errors++;
                $display("FAIL pixel_edge inst%0d: got %h expected %h", inst, obs(inst), exp_v[inst]);
            end
        end
    endtask

    // One clk with pix_en low: everything must hold.
    task automatic pix_idle(input int inst);
        @(posedge clk);
        #1;
        checks++;
        if (obs(inst) !== exp_v[inst]) begin
            errors++;
            $display("FAIL hold inst%0d: got %h expected %h", inst, obs(inst), exp_v[inst]);
        end
    endtask

    // Asynchronous reset pulse asserted away from the clock edge.
    task automatic do_reset(input int inst);
        if (inst == 0) rst_d = 1'b0; else rst_s = 1'b0;
        #5;
        checks++;
        if (obs(inst) !== RST_V) begin
            errors++;
            $display("FAIL async_reset inst%0d: got %h expected %h", inst, obs(inst), RST_V);
        end
        checks++;
        if (((inst == 0) ? sn_d : sn_s) !== 1'b0) begin
            errors++;
            $display("FAIL sync_n inst%0d: got %b expected 0", inst, (inst == 0) ? sn_d : sn_s);
        end
        @(posedge clk);
        #1;
        if (inst == 0) rst_d = 1'b1; else rst_s = 1'b1;
        mx[inst]    = 0;
        my[inst]    = 0;
        exp_v[inst] = RST_V;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset(0);
        do_reset(1);
        pix_idle(0);
        pix_idle(1);
    endtask

    task automatic test_first_edge();
        // Pixel (0,0): r=00 g=00 b=A5, visible, syncs idle; counters -> (1,0).
        pix_edge(0, 0);
        checks++;
        if (obs_d !== {10'd1, 10'd0, 1'b0, 24'h0000A5, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL first_edge: got %h expected %h", obs_d,
                     {10'd1, 10'd0, 1'b0, 24'h0000A5, 1'b1, 1'b1, 1'b1});
        end
    endtask

    task automatic test_line_sync();
        int hs_low, first_low, px, py;
        hs_low = 0;
        first_low = -1;
        for (int i = 0; i < 1599; i++) begin
            px = mx[0];
            py = my[0];
            pix_edge(0, 1);
            if (py == 0 && hs_d === 1'b0) begin
                hs_low++;
                if (first_low < 0) first_low = px;
            end
        end
        checks++;
        if (hs_low != 96) begin
            errors++;
            $display("FAIL hs_width: got %0d expected 96", hs_low);
        end
        checks++;
        if (first_low != 656) begin
            errors++;
            $display("FAIL hs_first_x: got %0d expected 656", first_low);
        end
    endtask

    task automatic test_mid_line_reset();
        for (int i = 0; i < 300; i++) pix_edge(0, 1);
        do_reset(0);
        pix_edge(0, 1);
    endtask

    task automatic test_half_rate();
        do_reset(0);
        for (int i = 0; i < 850; i++) begin
            pix_edge(0, 1);
            pix_idle(0);
        end
    endtask

    task automatic test_small_frame();
        int n, vs_low;
        do_reset(1);
        pix_edge(1, 1);
        n = 1;
        vs_low = 0;
        while (fs_s !== 1'b1 && n < 400) begin
            if (mx[1] == 24 && my[1] == 10) begin
                checks++;
                if ({x_s, y_s} !== {10'd24, 10'd10}) begin
                    errors++;
                    $display("FAIL pre_wrap: got %0d,%0d expected 24,10", x_s, y_s);
                end
                pix_edge(1, 1);
                checks++;
                if ({x_s, y_s, fs_s, vs_s} !== {20'd0, 1'b1, 1'b1}) begin
                    errors++;
                    $display("FAIL wrap: got %h expected %h", {x_s, y_s, fs_s, vs_s}, {20'd0, 1'b1, 1'b1});
                end
            end else begin
                pix_edge(1, 1);
            end
            if (vs_s === 1'b0) vs_low++;
            n++;
        end
        checks++;
        if (n != 275) begin
            errors++;
            $display("FAIL frame_period: got %0d expected 275", n);
        end
        checks++;
        if (vs_low != 50) begin
            errors++;
            $display("FAIL vs_width: got %0d expected 50", vs_low);
        end
    endtask

    task automatic test_small_half_rate();
        int fs_hi;
        do_reset(1);
        pix_edge(1, 1);
        pix_idle(1);
        fs_hi = 0;
        for (int i = 0; i < 275; i++) begin
            pix_edge(1, 1);
            if (fs_s === 1'b1) fs_hi++;
            pix_idle(1);
            if (fs_s === 1'b1) fs_hi++;
        end
        checks++;
        if (fs_hi != 2) begin
            errors++;
            $display("FAIL fs_half_rate: got %0d expected 2", fs_hi);
        end
    endtask

    task automatic test_small_mid_reset();
        int n;
        do_reset(1);
        for (int i = 0; i < 194; i++) pix_edge(1, 1);
        // Now at (19,7): previous pixel (18,7) has hs, vs low and blank.
        checks++;
        if ({x_s, y_s, hs_s, vs_s, bl_s} !== {10'd19, 10'd7, 3'b000}) begin
            errors++;
            $display("FAIL mid_frame_pos: got %h expected %h", {x_s, y_s, hs_s, vs_s, bl_s},
                     {10'd19, 10'd7, 3'b000});
        end
        do_reset(1);
        pix_edge(1, 1);
        n = 1;
        while (fs_s !== 1'b1 && n < 400) begin
            pix_edge(1, 1);
            n++;
        end
        checks++;
        if (n != 275) begin
            errors++;
            $display("FAIL period_after_reset: got %0d expected 275", n);
        end
    endtask

    task automatic test_bars();
        logic [23:0] want85, want639;
`ifdef VGA_SCAN_BARS_EN
        want85  = 24'h0000FF;
        want639 = 24'hFFFFFF;
`else
        want85  = 24'h121212;
        want639 = 24'h121212;
`endif
        data_mode = 1'b1;
        bar_en    = 1'b1;
        do_reset(0);
        for (int i = 0; i < 85; i++) pix_edge(0, 0);
        pix_edge(0, 0);
        checks++;
        if ({vr_d, vg_d, vb_d} !== want85) begin
            errors++;
            $display("FAIL bar_x85: got %h expected %h", {vr_d, vg_d, vb_d}, want85);
        end
        for (int i = 0; i < 553; i++) pix_edge(0, 0);
        pix_edge(0, 0);
        checks++;
        if ({vr_d, vg_d, vb_d} !== want639) begin
            errors++;
            $display("FAIL bar_x639: got %h expected %h", {vr_d, vg_d, vb_d}, want639);
        end
        pix_edge(0, 0);
        checks++;
        if ({vr_d, vg_d, vb_d, bl_d} !== 25'd0) begin
            errors++;
            $display("FAIL bar_x640_blank: got %h expected 0", {vr_d, vg_d, vb_d, bl_d});
        end
        bar_en = 1'b0;
        do_reset(0);
        for (int i = 0; i < 86; i++) pix_edge(0, 1);
        checks++;
        if ({vr_d, vg_d, vb_d} !== 24'h121212) begin
            errors++;
            $display("FAIL sprite_x85: got %h expected 121212", {vr_d, vg_d, vb_d});
        end
        data_mode = 1'b0;
    endtask

    // ---------------- sequence ----------------
    initial begin
        rst_d = 1'b1; rst_s = 1'b1;
        pe_d = 1'b0; pe_s = 1'b0;
        bar_en = 1'b0; data_mode = 1'b0;
        mx[0] = 0; my[0] = 0; mx[1] = 0; my[1] = 0;
        exp_v[0] = RST_V; exp_v[1] = RST_V;
        @(posedge clk);
        #1;
        test_reset();
        test_first_edge();
        test_line_sync();
        test_mid_line_reset();
        test_half_rate();
        test_small_frame();
        test_small_half_rate();
        test_small_mid_reset();
        test_bars();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Overall time bound.
    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vga_scan_ctrl.md
# vga_scan_ctrl

VGA scan controller for the DE2-115 display path: generates the `x_cnt`/`y_cnt` raster coordinates consumed by the card-number and card-face sprite layers and captures their `r_data`/`g_data`/`b_data` reply. It drives the ADV7123 DAC pins with blanking and sync aligned to the registered pixel data. Default timing is 640x480@60 with a 25 MHz pixel rate.

## Interface

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_en  in  1  pixel-rate enable; tie high when clk is the 25 MHz pixel clock
- r_data / g_data / b_data  in  8 each  colour returned by the sprite layers for the current `x_cnt`/`y_cnt`
- bar_en  in  1  test-bar select; only effective with `VGA_SCAN_BARS_EN`
- x_cnt  out  10  horizontal position; 0..H_ACTIVE-1 is visible
- y_cnt  out  10  vertical position; 0..V_ACTIVE-1 is visible
- frame_start  out  1  high while counters are at (0,0)
- vga_r / vga_g / vga_b  out  8 each  DAC colour
- vga_hs / vga_vs  out  1  syncs, active-low
- vga_blank_n  out  1  low outside the visible area
- vga_sync_n  out  1  constant 0 (no sync-on-green)

## Operation

- Totals are H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Line layout is active, front porch, sync, back porch. Frame layout follows the same order.
- Counters advance only on cycles with pix_en=1:
  - x_cnt increments and wraps from H_TOTAL-1 to 0.
  - y_cnt increments only on the x wrap, and wraps from V_TOTAL-1 to 0.
- active = (x_cnt < H_ACTIVE) && (y_cnt < V_ACTIVE).
- hs_n is low when x_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
- vs_n is low when y_cnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491. vs_n is a function of y_cnt only.
- The sprite layers are combinational from x_cnt/y_cnt. Data returned in cycle t is sampled at the next pix_en edge.
- On each pix_en edge:
  - vga_r/g/b <= active ? {r,g,b}_data : 0.
  - vga_blank_n <= active.
  - vga_hs <= hs_n and vga_vs <= vs_n, both computed from the pre-increment counters.
- frame_start is registered. It is high exactly while x_cnt=0 and y_cnt=0, for every clk of that pixel slot.
- Counters never exceed H_TOTAL-1 / V_TOTAL-1. Out-of-range values cannot occur after reset.

## Timing

- Reset (asynchronous, any time, including mid-frame) forces:
  - x_cnt=0, y_cnt=0, frame_start=1
  - vga_r/g/b=0, vga_blank_n=0, vga_hs=1, vga_vs=1, vga_sync_n=0
- On release, the first pix_en edge latches pixel (0,0) and moves the counters to (1,0).
- Pipeline latency: counters to DAC pins = 1 pix_en edge. hs, vs, blank_n and RGB stay mutually aligned.
- pix_en=0 freezes all registers, with no skipped or duplicated pixels.
- A 1-in-2 pix_en duty on a 50 MHz clk yields identical pin sequences at half rate.
- Wrap events:
  - x wrap at y=V_TOTAL-1 produces the y wrap on the same edge.
  - frame_start rises on that edge.

## Configuration

- `VGA_SCAN_BARS_EN` defined: when bar_en=1, active pixels show 8 vertical bars, each H_ACTIVE/8 = 80 px wide.
  - Bar index b = x_cnt/80.
  - Colour is r=b[2]?FF:00, g=b[1]?FF:00, b=b[0]?FF:00, in order black, blue, green, cyan, red, magenta, yellow, white.
  - r/g/b_data are ignored while bar_en=1.
- Not defined: bar_en is ignored, no bar logic is synthesized, and the pins always carry sprite data.

## Test plan

- Reset mid-frame at (300,200) -> counters read (0,0) asynchronously; vga_hs=vga_vs=1, blank_n=0, RGB=0; after release, frame period = 420000 pix_en edges.
- pix_en=1, r/g/b_data = x_cnt[7:0] -> at line 0, vga_r equals the previous x_cnt for x 1..640; vga_r=0 and blank_n=0 for x 641..799.
- Sync positions -> vga_hs low for exactly 96 pixels, first low edge when the previous x_cnt=656; vga_vs low for exactly 2 lines (y 490..491), i.e. 1600 pixels.
- pix_en alternating 1/0 -> each pin value held 2 clks; frame_start high 2 clks per frame; sequence otherwise identical to the continuous run.
- Wrap at (799,524) -> next edge gives (0,0), frame_start=1; vga_vs remains high.
- With `VGA_SCAN_BARS_EN` and bar_en=1, r/g/b_data=0x12 -> pixel x=85 gives 00/00/FF and x=639 gives FF/FF/FF; with bar_en=0, pins carry 0x12.
